// File: rtl/key_repeat.sv
// Keyboard-to-game-action conditioner: turns a held HID keycode into one-frame
// move/rotate/drop strobes with delayed auto-shift and auto-repeat.
module key_repeat #(
    parameter int unsigned DAS_FRAMES  = 10,
    parameter int unsigned ARR_FRAMES  = 3,
    parameter int unsigned DROP_FRAMES = 2
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       enable,
    output logic       move_left,
    output logic       move_right,
    output logic       soft_drop,
    output logic       rotate,
    output logic       hard_drop,
    output logic [7:0] held_key
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT,
        ONCE
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_LEFT,
        ACT_RIGHT,
        ACT_DROP,
        ACT_ROTATE,
        ACT_HARD
    } action_t;

    localparam logic [7:0] KEY_LEFT   = 8'h04;
    localparam logic [7:0] KEY_RIGHT  = 8'h07;
    localparam logic [7:0] KEY_DROP   = 8'h16;
    localparam logic [7:0] KEY_ROTATE = 8'h1A;
    localparam logic [7:0] KEY_HARD   = 8'h2C;

    // Compare values are "frames minus one" so a parameter of 1 fires every frame.
    localparam logic [7:0] DAS_LAST  = 8'(DAS_FRAMES - 1);
    localparam logic [7:0] ARR_LAST  = 8'(ARR_FRAMES - 1);
    localparam logic [7:0] DROP_LAST = 8'(DROP_FRAMES - 1);

    state_t     state, state_next;
    logic [7:0] count, count_next;
    logic [7:0] held_next;
    logic       fire;

    action_t    action;
    logic       repeatable;
    logic [7:0] delay_last;
    logic [7:0] repeat_last;

    logic       move_left_next;
    logic       move_right_next;
    logic       soft_drop_next;
    logic       rotate_next;
    logic       hard_drop_next;

    // Keycode decode: which action, whether it auto-repeats, and its timing.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        action      = ACT_NONE;
        repeatable  = 1'b0;
        delay_last  = DAS_LAST;
        repeat_last = ARR_LAST;
        case (keycode)
            KEY_LEFT: begin
                action     = ACT_LEFT;
                repeatable = 1'b1;
            end
            KEY_RIGHT: begin
                action     = ACT_RIGHT;
                repeatable = 1'b1;
            end
            KEY_DROP: begin
                action      = ACT_DROP;
                repeatable  = 1'b1;
                delay_last  = DROP_LAST;
                repeat_last = DROP_LAST;
            end
            KEY_ROTATE: action = ACT_ROTATE;
            KEY_HARD:   action = ACT_HARD;
            default:    action = ACT_NONE;
        endcase
    end

    // Next-state logic, evaluated in strict priority order.
    always_comb begin
        state_next = state;
        count_next = count;
        held_next  = held_key;
        fire       = 1'b0;

        if (!enable || action == ACT_NONE) begin
            state_next = IDLE;
            count_next = 8'd0;
            held_next  = 8'h00;
        end else if (keycode != held_key) begin
            // A fresh press (or a direct key switch) pre-empts any repeat that was due.
            fire       = 1'b1;
            held_next  = keycode;
            count_next = 8'd0;
            state_next = repeatable ? DELAY : ONCE;
        end else begin
            case (state)
                DELAY: begin
                    if (count == delay_last) begin
                        fire       = 1'b1;
                        count_next = 8'd0;
                        state_next = REPEAT;
                    end else begin
                        count_next = count + 8'd1;
                    end
                end
                REPEAT: begin
                    if (count == repeat_last) begin
                        fire       = 1'b1;
                        count_next = 8'd0;
                    end else begin
                        count_next = count + 8'd1;
                    end
                end
                ONCE: begin
                    state_next = ONCE;
                end
                default: begin
                    state_next = IDLE;
                    count_next = 8'd0;
                    held_next  = 8'h00;
                end
            endcase
        end
    end

    // One strobe per firing action, so at most one output is ever high.
    always_comb begin
        move_left_next  = 1'b0;
        move_right_next = 1'b0;
        soft_drop_next  = 1'b0;
        rotate_next     = 1'b0;
        hard_drop_next  = 1'b0;
        if (fire) begin
            case (action)
                ACT_LEFT:   move_left_next  = 1'b1;
                ACT_RIGHT:  move_right_next = 1'b1;
                ACT_DROP:   soft_drop_next  = 1'b1;
                ACT_ROTATE: rotate_next     = 1'b1;
                ACT_HARD:   hard_drop_next  = 1'b1;
                default:    move_left_next  = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            count      <= 8'd0;
            held_key   <= 8'h00;
            move_left  <= 1'b0;
            move_right <= 1'b0;
            soft_drop  <= 1'b0;
            rotate     <= 1'b0;
            hard_drop  <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            held_key   <= held_next;
            move_left  <= move_left_next;
            move_right <= move_right_next;
            soft_drop  <= soft_drop_next;
            rotate     <= rotate_next;
            hard_drop  <= hard_drop_next;
        end
    end

endmodule

// File: tb/tb_key_repeat.sv
// Self-checking bench for key_repeat: a press-age model checked every frame,
// plus directed scenarios with hand-computed strobe timing.
module tb_key_repeat;

    localparam int DAS  = 10;
    localparam int ARR  = 3;
    localparam int DROP = 2;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b0;
    logic [7:0] keycode   = 8'h00;
    logic       enable    = 1'b0;
    logic       move_left, move_right, soft_drop, rotate, hard_drop;
    logic [7:0] held_key;

    int total = 0;
    int bad   = 0;

    key_repeat #(
        .DAS_FRAMES (DAS),
        .ARR_FRAMES (ARR),
        .DROP_FRAMES(DROP)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .enable    (enable),
        .move_left (move_left),
        .move_right(move_right),
        .soft_drop (soft_drop),
        .rotate    (rotate),
        .hard_drop (hard_drop),
        .held_key  (held_key)
    );

    always #5 frame_clk = ~frame_clk;

    // Strobe vector order: {left, right, soft_drop, rotate, hard_drop}.
    wire [4:0] dut_s = {move_left, move_right, soft_drop, rotate, hard_drop};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] act_bits(input logic [7:0] k);
        case (k)
            8'h04:   return 5'b10000;
            8'h07:   return 5'b01000;
            8'h16:   return 5'b00100;
            8'h1A:   return 5'b00010;
            8'h2C:   return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    // A key held n frames after its press fires at n = D, D+R, D+2R, ...
    function automatic bit due(input logic [7:0] k, input int n);
        int d, r;
        if (!(k == 8'h04 || k == 8'h07 || k == 8'h16)) return 1'b0;
        d = (k == 8'h16) ? DROP : DAS;
        r = (k == 8'h16) ? DROP : ARR;
        return (n >= d) && ((n - d) % r == 0);
    endfunction

    logic [7:0] trk   = 8'h00;
    int         since = 0;
    logic [4:0] exp_s = 5'b0;
    logic [7:0] exp_h = 8'h00;

    always @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            trk   <= 8'h00;
            since <= 0;
            exp_s <= 5'b0;
            exp_h <= 8'h00;
        end else if (!enable || act_bits(keycode) == 5'b0) begin
            trk   <= 8'h00;
            since <= 0;
            exp_s <= 5'b0;
            exp_h <= 8'h00;
        end else if (keycode != trk) begin
            trk   <= keycode;
            since <= 0;
            exp_s <= act_bits(keycode);
            exp_h <= keycode;
        end else begin
            since <= since + 1;
            exp_s <= due(keycode, since + 1) ? act_bits(keycode) : 5'b0;
            exp_h <= keycode;
        end
    end

    always @(negedge frame_clk) begin
        check("strobes", 32'(dut_s), 32'(exp_s));
        check("held_key", 32'(held_key), 32'(exp_h));
        check("one_strobe", 32'($countones(dut_s) <= 1), 32'd1);
    end

    // Drive one frame's inputs, then wait until the following negedge where the
    // strobe produced by that edge is visible.
    task automatic tick(input logic [7:0] k, input logic en);
        keycode = k;
        enable  = en;
        @(negedge frame_clk);
    endtask

    logic [31:0] mask_a, mask_b;

    initial begin
        // Reset held low with a key down: everything stays cleared.
        Reset   = 1'b0;
        keycode = 8'h04;
        enable  = 1'b1;
        repeat (3) @(negedge frame_clk);
        check("reset_strobes", 32'(dut_s), 32'd0);
        check("reset_held", 32'(held_key), 32'h00);
        #2 Reset = 1'b1;
        tick(8'h04, 1'b1);
        check("first_left", 32'(move_left), 32'd1);
        check("first_held", 32'(held_key), 32'h04);
        tick(8'h04, 1'b1);
        check("left_one_cycle", 32'(move_left), 32'd0);
        tick(8'h00, 1'b1);
        check("release_held", 32'(held_key), 32'h00);

        // Right held 20 frames: 0, 10, 13, 16, 19.
        mask_a = '0;
        for (int i = 0; i < 20; i++) begin
            tick(8'h07, 1'b1);
            mask_a[i] = move_right;
        end
        check("right_das_arr", mask_a, 32'h0009_2401);
        tick(8'h00, 1'b1);

        // Soft drop held 8 frames: 0, 2, 4, 6.
        mask_a = '0;
        for (int i = 0; i < 8; i++) begin
            tick(8'h16, 1'b1);
            mask_a[i] = soft_drop;
        end
        check("soft_drop_rate", mask_a, 32'h0000_0055);
        tick(8'h00, 1'b1);

        // Rotate held 30 frames fires once; a one-frame release re-arms it.
        mask_a = '0;
        for (int i = 0; i < 30; i++) begin
            tick(8'h1A, 1'b1);
            mask_a[i] = rotate;
        end
        check("rotate_once", mask_a, 32'h0000_0001);
        tick(8'h00, 1'b1);
        tick(8'h1A, 1'b1);
        check("rotate_retap", 32'(rotate), 32'd1);
        tick(8'h00, 1'b1);

        // Left to edge 12, then right at edge 13 where a left repeat was due.
        mask_a = '0;
        mask_b = '0;
        for (int i = 0; i < 25; i++) begin
            tick((i < 13) ? 8'h04 : 8'h07, 1'b1);
            mask_a[i] = move_left;
            mask_b[i] = move_right;
        end
        check("switch_left", mask_a, 32'h0000_0401);
        check("switch_right", mask_b, 32'h0080_2000);
        tick(8'h00, 1'b1);

        // Hard drop with enable low for edges 3..5: fires at 0 and 6.
        mask_a = '0;
        mask_b = '0;
        for (int i = 0; i < 7; i++) begin
            tick(8'h2C, (i < 3 || i >= 6));
            mask_a[i] = hard_drop;
            mask_b[i] = |dut_s[4:1];
        end
        check("hard_drop_enable", mask_a, 32'h0000_0041);
        check("others_quiet", mask_b, 32'h0000_0000);

        // Mid-cycle reset clears the live strobe at once; the held key re-fires after.
        #2 Reset = 1'b0;
        #1;
        check("async_strobes", 32'(dut_s), 32'd0);
        check("async_held", 32'(held_key), 32'h00);
        @(negedge frame_clk);
        #2 Reset = 1'b1;
        tick(8'h2C, 1'b1);
        check("repress_after_reset", 32'(hard_drop), 32'd1);
        tick(8'h00, 1'b1);
        tick(8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
